// File: rtl/cim_psum_collector.sv
// Partial-sum collector: accepts n_tiles psum vectors per job, sums them per column
// into signed accumulators, then offers the result downstream over valid/ready.
module cim_psum_collector #(
    parameter int NUM_COLS   = 32,
    parameter int PSUM_WIDTH = 21,
    parameter int MAX_TILES  = 8,
    parameter int CNT_WIDTH  = $clog2(MAX_TILES + 1),
    parameter int ACC_WIDTH  = PSUM_WIDTH + $clog2(MAX_TILES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [CNT_WIDTH-1:0]            cfg_num_tiles,
    input  logic [NUM_COLS*PSUM_WIDTH-1:0]  psum_in,
    input  logic                            psum_data_ready,
    output logic                            psum_ack,
    output logic [NUM_COLS*ACC_WIDTH-1:0]   out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_WIDTH-1:0]   r_tile_cnt;
    logic [CNT_WIDTH-1:0]   r_n_tiles;
    logic [CNT_WIDTH-1:0]   w_n_tiles;
    logic                   r_done;
    logic                   w_xfer;
    logic                   w_last;
    logic [ACC_WIDTH-1:0]   r_acc      [NUM_COLS];
    logic [ACC_WIDTH-1:0]   w_psum_ext [NUM_COLS];

    // Handshakes: a psum moves on any posedge where psum_data_ready & psum_ack are both 1;
    // the result moves on any posedge where out_valid & out_ready are both 1.
    assign psum_ack    = (r_state == S_COLLECT);
    assign out_valid   = (r_state == S_OUTPUT);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign o_dbg_state = r_state;

    assign w_xfer = psum_data_ready & psum_ack;
    assign w_last = (r_tile_cnt == r_n_tiles - CNT_WIDTH'(1));

    genvar g;
    generate
        for (g = 0; g < NUM_COLS; g++) begin : g_col
            assign w_psum_ext[g] = {{(ACC_WIDTH-PSUM_WIDTH){psum_in[g*PSUM_WIDTH + PSUM_WIDTH - 1]}},
                                    psum_in[g*PSUM_WIDTH +: PSUM_WIDTH]};
            assign out_data[g*ACC_WIDTH +: ACC_WIDTH] = r_acc[g];
        end
    endgenerate

    // A zero tile count still runs one pass; oversize counts clamp to MAX_TILES.
    always_comb begin
        w_n_tiles = cfg_num_tiles;
        if (cfg_num_tiles == '0) begin
            w_n_tiles = CNT_WIDTH'(1);
        end else if (cfg_num_tiles > CNT_WIDTH'(MAX_TILES)) begin
            w_n_tiles = CNT_WIDTH'(MAX_TILES);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start)            w_next_state = S_COLLECT;
            S_COLLECT: if (w_xfer && w_last) w_next_state = S_OUTPUT;
            S_OUTPUT:  if (out_ready)        w_next_state = S_IDLE;
            default:                         w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tile_cnt <= '0;
            r_n_tiles  <= CNT_WIDTH'(1);
            r_done     <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == S_OUTPUT) && out_ready;
            if ((r_state == S_IDLE) && start) begin
                r_n_tiles  <= w_n_tiles;
                r_tile_cnt <= '0;
            end
            // First transfer of a job overwrites, so the previous result never leaks in.
            if (w_xfer) begin
                r_tile_cnt <= r_tile_cnt + CNT_WIDTH'(1);
                for (int c = 0; c < NUM_COLS; c++) begin
                    r_acc[c] <= ((r_tile_cnt == '0) ? '0 : r_acc[c]) + w_psum_ext[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_cim_psum_collector.sv
// Directed bench for cim_psum_collector: hand-computed sums on columns 0, 5 and 31,
// handshake timing, tile-count clamping, reset abort and back-to-back jobs.
module tb_cim_psum_collector;

    localparam int NC = 32;
    localparam int PW = 21;
    localparam int AW = 24;
    localparam int CW = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic [CW-1:0]      cfg_num_tiles;
    logic [NC*PW-1:0]   psum_in;
    logic               psum_data_ready;
    logic               psum_ack;
    logic [NC*AW-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic [1:0]         o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_seen = 0;
    int ack_base;

    cim_psum_collector dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_num_tiles   (cfg_num_tiles),
        .psum_in         (psum_in),
        .psum_data_ready (psum_data_ready),
        .psum_ack        (psum_ack),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .done            (done),
        .o_dbg_state     (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent transfer counter, sampled mid-cycle when both handshake lines are stable.
    always @(negedge clk) begin
        if (psum_ack && psum_data_ready) ack_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int col(input int c);
        logic [AW-1:0] v;
        v = out_data[c*AW +: AW];
        return int'($signed(v));
    endfunction

    function automatic logic [NC*PW-1:0] mk(input int v0, input int v5, input int v31);
        logic [NC*PW-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++) v[c*PW +: PW] = PW'(c);
        v[0*PW +: PW]  = PW'(v0);
        v[5*PW +: PW]  = PW'(v5);
        v[31*PW +: PW] = PW'(v31);
        return v;
    endfunction

    task automatic do_start(input logic [CW-1:0] c);
        start = 1'b1;
        cfg_num_tiles = c;
        tick();
        start = 1'b0;
        check("start_ack", 32'(psum_ack), 32'd1);
    endtask

    task automatic send(input int gap, input logic [NC*PW-1:0] v);
        psum_data_ready = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
            check("ack_gap", 32'(psum_ack), 32'd1);
        end
        psum_in = v;
        psum_data_ready = 1'b1;
        tick();
        psum_data_ready = 1'b0;
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("valid_drop", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        tick();
        check("done_one", 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_num_tiles = '0; psum_in = '0;
        psum_data_ready = 1'b0; out_ready = 1'b0;

        // 1: reset, abort mid-job, fresh single-tile job
        tick(); tick();
        check("rst_ack", 32'(psum_ack), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'd0);
        check("rst_out", 32'(out_data == '0), 32'd1);
        rst = 1'b0;
        tick();
        do_start(4'd4);
        send(0, mk(1000, 1000, 1000));
        send(0, mk(1000, 1000, 1000));
        rst = 1'b1;
        tick(); tick();
        check("abort_ack", 32'(psum_ack), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out", 32'(out_data == '0), 32'd1);
        rst = 1'b0;
        tick();
        do_start(4'd1);
        send(0, mk(5, 5, 5));
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_col0", 32'(col(0)), 32'd5);
        check("t1_col31", 32'(col(31)), 32'd5);
        finish_out();

        // 2: signed sums and max-magnitude column
        do_start(4'd4);
        send(0, mk(100, -(1 << 20), (1 << 20) - 1));
        send(0, mk(-30, -(1 << 20), (1 << 20) - 1));
        send(0, mk(7, -(1 << 20), (1 << 20) - 1));
        check("t2_not_yet", 32'(out_valid), 32'd0);
        send(0, mk(1, -(1 << 20), (1 << 20) - 1));
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_ack_off", 32'(psum_ack), 32'd0);
        check("t2_col0", 32'(col(0)), 32'd78);
        check("t2_col5", 32'(col(5)), 32'(-4194304));
        check("t2_col31", 32'(col(31)), 32'd4194300);
        check("t2_col9", 32'(col(9)), 32'd36);
        finish_out();

        // 3: producer gaps
        ack_base = ack_seen;
        do_start(4'd3);
        send(0, mk(10, -1, 1));
        send(2, mk(20, -2, 2));
        send(5, mk(30, -3, 3));
        check("t3_acks", 32'(ack_seen - ack_base), 32'd3);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_col0", 32'(col(0)), 32'd60);
        check("t3_col5", 32'(col(5)), 32'(-6));
        finish_out();

        // 4: downstream backpressure with producer still asserting
        ack_base = ack_seen;
        do_start(4'd2);
        send(0, mk(3, 0, 0));
        send(0, mk(4, 0, 0));
        psum_in = mk(999, 999, 999);
        psum_data_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_ack", 32'(psum_ack), 32'd0);
            check("t4_hold_col0", 32'(col(0)), 32'd7);
            check("t4_hold_done", 32'(done), 32'd0);
        end
        psum_data_ready = 1'b0;
        finish_out();
        check("t4_acks", 32'(ack_seen - ack_base), 32'd2);

        // 5: tile-count clamping and ignored start
        ack_base = ack_seen;
        do_start(4'd0);
        send(0, mk(9, 0, 0));
        check("t5_cfg0_valid", 32'(out_valid), 32'd1);
        check("t5_cfg0_col0", 32'(col(0)), 32'd9);
        finish_out();
        do_start(4'd15);
        for (int i = 0; i < 7; i++) begin
            send(0, mk(1, 0, 0));
            check("t5_clamp_wait", 32'(out_valid), 32'd0);
            if (i == 2) begin
                start = 1'b1;
                cfg_num_tiles = 4'd1;
                tick();
                start = 1'b0;
                check("t5_ign_busy", 32'(busy), 32'd1);
                check("t5_ign_ack", 32'(psum_ack), 32'd1);
            end
        end
        send(0, mk(1, 0, 0));
        check("t5_clamp_valid", 32'(out_valid), 32'd1);
        check("t5_clamp_col0", 32'(col(0)), 32'd8);
        check("t5_acks", 32'(ack_seen - ack_base), 32'd9);
        finish_out();

        // 6: start on the done cycle; new job loads instead of adding
        do_start(4'd1);
        send(0, mk(50, 50, 50));
        check("t6_j1_col0", 32'(col(0)), 32'd50);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t6_done", 32'(done), 32'd1);
        start = 1'b1;
        cfg_num_tiles = 4'd2;
        tick();
        start = 1'b0;
        check("t6_b2b_ack", 32'(psum_ack), 32'd1);
        check("t6_b2b_done", 32'(done), 32'd0);
        send(0, mk(11, 0, 0));
        send(0, mk(12, 0, 0));
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_col0", 32'(col(0)), 32'd23);
        check("t6_col31", 32'(col(31)), 32'd0);
        finish_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
